and_frame_reducer: RTL and testbench

//   Sequential consumer for the bitwise AND datapath: accepts a frame of WIDTH-bit

---
 rtl/and_frame_reducer.sv | 89 ++++++++
 tb/tb_and_frame_reducer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/and_frame_reducer.sv
// Purpose: reduces a valid/ready frame of WIDTH-bit words to their bitwise AND, word count and all-ones flag.
// Latency: result is presented (out_valid=1) in the cycle after the last word is accepted.
// Backpressure: while a result is held, in_ready=0 and the result stays stable until out_ready is seen high.
module and_frame_reducer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_all_ones
);

    // Two-state controller: collecting words, or holding a finished result.
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             release_result;

    // Handshake outputs depend only on the state register, so no input reaches an output combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    // Next running AND and saturating word count; the AND stays exact even once the count pins at max.
    always_comb begin
        acc_next       = acc & in_data;
        cnt_inc        = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);
        accept         = (state == ACCUM) && in_valid;
        release_result = (state == HOLD) && out_ready;
    end

    // State, accumulator and result registers; reset discards any partial frame or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= ALL_ONES;
            cnt          <= '0;
            out_data     <= '0;
            out_count    <= '0;
            out_all_ones <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_data     <= acc_next;
                            out_count    <= cnt_inc;
                            out_all_ones <= &acc_next;
                            acc          <= ALL_ONES;
                            cnt          <= '0;
                            state        <= HOLD;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    // Input side is ignored here; result registers keep their value after release.
                    if (release_result) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_frame_reducer.sv
// Bench for and_frame_reducer: two instances (CNT_W=8 and CNT_W=2) driven in lockstep.
// Expected results are queued per instance by the stimulus and popped by a monitor on each result handshake.
// Direct checks cover reset values, latency, backpressure stability and release timing.
module tb_and_frame_reducer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_all_ones_a;
    logic [7:0] out_data_a, out_count_a;
    logic       in_ready_b, out_valid_b, out_all_ones_b;
    logic [7:0] out_data_b;
    logic [1:0] out_count_b;

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
        logic       ao;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks;
    int failures;

    and_frame_reducer #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_count(out_count_a), .out_all_ones(out_all_ones_a)
    );

    and_frame_reducer #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_count(out_count_b), .out_all_ones(out_all_ones_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic expect_frame(input logic [7:0] d, input logic [7:0] ca,
                                input logic [7:0] cb, input logic ao);
        exp_t e;
        e.d = d; e.c = ca; e.ao = ao;
        exp_a.push_back(e);
        e.c = cb;
        exp_b.push_back(e);
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        check("in_ready_before_send_a", {31'd0, in_ready_a}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    // Monitor: pops and compares on every result handshake (sampled on the falling edge).
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready) begin
            if (exp_a.size() == 0) begin
                check("sb_a_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_a.pop_front();
                check("sb_a_data", {24'd0, out_data_a}, {24'd0, e.d});
                check("sb_a_count", {24'd0, out_count_a}, {24'd0, e.c});
                check("sb_a_all_ones", {31'd0, out_all_ones_a}, {31'd0, e.ao});
            end
        end
        if (!rst && out_valid_b && out_ready) begin
            if (exp_b.size() == 0) begin
                check("sb_b_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                check("sb_b_data", {24'd0, out_data_b}, {24'd0, e.d});
                check("sb_b_count", {30'd0, out_count_b}, {24'd0, e.c});
                check("sb_b_all_ones", {31'd0, out_all_ones_b}, {31'd0, e.ao});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_out_data", {24'd0, out_data_a}, 32'd0);
        check("rst_out_count", {24'd0, out_count_a}, 32'd0);
        check("rst_out_all_ones", {31'd0, out_all_ones_a}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("rst_in_ready_b", {31'd0, in_ready_b}, 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Three-word frame: FF & F0 & 3C = 30.
        expect_frame(8'h30, 8'd3, 8'd3, 1'b0);
        send_word(8'hFF, 1'b0);
        send_word(8'hF0, 1'b0);
        check("no_early_valid", {31'd0, out_valid_a}, 32'd0);
        send_word(8'h3C, 1'b1);
        check("lat_out_valid", {31'd0, out_valid_a}, 32'd1);
        check("lat_in_ready", {31'd0, in_ready_a}, 32'd0);
        check("lat_out_data", {24'd0, out_data_a}, 32'h30);
        @(posedge clk);
        #1;
        check("release_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("release_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("release_data_kept", {24'd0, out_data_a}, 32'h30);

        // Single-word frame of all ones.
        expect_frame(8'hFF, 8'd1, 8'd1, 1'b1);
        send_word(8'hFF, 1'b1);
        check("single_all_ones", {31'd0, out_all_ones_a}, 32'd1);
        @(posedge clk);
        #1;

        // Frame whose AND collapses to zero.
        expect_frame(8'h00, 8'd2, 8'd2, 1'b0);
        send_word(8'h81, 1'b0);
        send_word(8'h7E, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure: result held for 5 cycles while input pulses are ignored.
        out_ready = 1'b0;
        expect_frame(8'h05, 8'd2, 8'd2, 1'b0);
        send_word(8'hA5, 1'b0);
        send_word(8'h5F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'h00;
            in_last  = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid_a}, 32'd1);
            check("bp_out_data", {24'd0, out_data_a}, 32'h05);
            check("bp_out_count", {24'd0, out_count_a}, 32'd2);
            check("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("bp_release_data_kept", {24'd0, out_data_a}, 32'h05);

        // Six all-ones words: count 6 on the wide counter, saturates at 3 on the 2-bit one.
        expect_frame(8'hFF, 8'd6, 8'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_word(8'hFF, (i == 5));
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a frame discards the partial accumulation.
        send_word(8'h0F, 1'b0);
        send_word(8'h0E, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_data", {24'd0, out_data_a}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid_a}, 32'd0);
        expect_frame(8'hAA, 8'd1, 8'd1, 1'b0);
        send_word(8'hAA, 1'b1);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        check("sb_a_drained", exp_a.size(), 32'd0);
        check("sb_b_drained", exp_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
